// File: rtl/vertex_viewport.sv
// vertex_viewport
//   Takes one clip-space vertex (x,y,z,w), divides x, y and z by w with a
//   single shared restoring divider to get NDC, then maps NDC x,y onto the
//   screen. One vertex is in flight at a time; valid/ready on both sides.
//
// Ports
//   i_clk, i_reset      clock, synchronous active-high reset
//   i_valid / o_ready   input handshake (o_ready high only while idle)
//   i_x,i_y,i_z,i_w     clip-space vertex, signed Q15.16
//   i_screen_width/height  screen size, Q15.16, captured on accept
//   o_valid / i_ready   output handshake
//   o_x, o_y            screen-space position
//   o_z                 NDC depth
//   o_w                 clip-space w passed through
//   o_reject            vertex had w <= 0, x/y/z forced to zero
module vertex_viewport #(
  parameter int FRAC_BITS = 16,
  parameter int WIDTH     = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_x,
  input  logic [WIDTH-1:0] i_y,
  input  logic [WIDTH-1:0] i_z,
  input  logic [WIDTH-1:0] i_w,
  input  logic [WIDTH-1:0] i_screen_width,
  input  logic [WIDTH-1:0] i_screen_height,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_x,
  output logic [WIDTH-1:0] o_y,
  output logic [WIDTH-1:0] o_z,
  output logic [WIDTH-1:0] o_w,
  output logic             o_reject
);

  localparam int QW = WIDTH + FRAC_BITS;
  localparam int CW = $clog2(QW);
  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};

  typedef enum logic [2:0] {
    IDLE, DIV_X, DIV_Y, DIV_Z, VIEWPORT, OUTPUT
  } state_t;

  state_t state, nextState;

  logic [WIDTH-1:0] xReg, yReg, zReg, wReg;
  logic [WIDTH-1:0] halfW, halfH;
  logic [WIDTH-1:0] ndcX, ndcY, ndcZ;
  logic [WIDTH-1:0] remReg;
  logic [QW-1:0]    divQuo;
  logic [CW-1:0]    bitCount;

  logic [WIDTH:0]   remShift;
  logic [WIDTH:0]   remDiff;
  logic             qBit;
  logic [WIDTH-1:0] remNext;
  logic [QW-1:0]    divQuoNext;
  logic             lastStep;
  logic [WIDTH-1:0] curNum;
  logic [WIDTH-1:0] stageResult;

  // |num| << FRAC_BITS; the most negative input becomes the unsigned 2^(WIDTH-1).
  function automatic logic [QW-1:0] absShift(input logic [WIDTH-1:0] num);
    logic [WIDTH-1:0] mag;
    mag = num[WIDTH-1] ? (~num + 1'b1) : num;
    return {mag, {FRAC_BITS{1'b0}}};
  endfunction

  // Clamp the unsigned quotient to the largest positive word, then apply sign.
  function automatic logic [WIDTH-1:0] finishQuotient(input logic [QW-1:0] q, input logic neg);
    logic [WIDTH-1:0] mag;
    mag = (q > {{FRAC_BITS{1'b0}}, MAX_POS}) ? MAX_POS : q[WIDTH-1:0];
    return neg ? (~mag + 1'b1) : mag;
  endfunction

  // Full-width signed product, floor-shifted back to the fixed-point scale.
  function automatic logic [WIDTH-1:0] fixMul(input logic signed [WIDTH-1:0] a,
                                              input logic signed [WIDTH-1:0] b);
    logic signed [2*WIDTH-1:0] p;
    p = a * b;
    return WIDTH'(p >>> FRAC_BITS);
  endfunction

  assign o_ready = (state == IDLE);
  assign o_valid = (state == OUTPUT);

  // One restoring-divide step. divQuo holds the unconsumed dividend bits in
  // its top end and collects quotient bits at the bottom, so after QW steps
  // it contains the full quotient.
  assign remShift   = {remReg, divQuo[QW-1]};
  assign remDiff    = remShift - {1'b0, wReg};
  assign qBit       = (remShift >= {1'b0, wReg});
  assign remNext    = qBit ? remDiff[WIDTH-1:0] : remShift[WIDTH-1:0];
  assign divQuoNext = {divQuo[QW-2:0], qBit};
  assign lastStep   = (bitCount == CW'(QW - 1));

  // Numerator of the division currently running, for its sign.
  always_comb begin
    curNum = xReg;
    case (state)
      DIV_Y:   curNum = yReg;
      DIV_Z:   curNum = zReg;
      default: curNum = xReg;
    endcase
  end

  assign stageResult = finishQuotient(divQuoNext, curNum[WIDTH-1]);

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) state <= IDLE;
    else         state <= nextState;
  end

  // Next-state logic. Non-positive w skips the divider entirely.
  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (i_valid) begin
          if ($signed(i_w) <= 0) nextState = OUTPUT;
          else                   nextState = DIV_X;
        end
      end
      DIV_X:    if (lastStep) nextState = DIV_Y;
      DIV_Y:    if (lastStep) nextState = DIV_Z;
      DIV_Z:    if (lastStep) nextState = VIEWPORT;
      VIEWPORT: nextState = OUTPUT;
      OUTPUT:   if (i_ready) nextState = IDLE;
      default:  nextState = IDLE;
    endcase
  end

  // Datapath: capture on accept, run the three divisions back to back,
  // then the viewport transform. Outputs only change on a reject accept
  // or in VIEWPORT, so they are held while waiting in OUTPUT.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      xReg     <= '0;
      yReg     <= '0;
      zReg     <= '0;
      wReg     <= '0;
      halfW    <= '0;
      halfH    <= '0;
      ndcX     <= '0;
      ndcY     <= '0;
      ndcZ     <= '0;
      remReg   <= '0;
      divQuo   <= '0;
      bitCount <= '0;
      o_x      <= '0;
      o_y      <= '0;
      o_z      <= '0;
      o_w      <= '0;
      o_reject <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_valid) begin
            xReg     <= i_x;
            yReg     <= i_y;
            zReg     <= i_z;
            wReg     <= i_w;
            halfW    <= WIDTH'($signed(i_screen_width) >>> 1);
            halfH    <= WIDTH'($signed(i_screen_height) >>> 1);
            remReg   <= '0;
            divQuo   <= absShift(i_x);
            bitCount <= '0;
            if ($signed(i_w) <= 0) begin
              o_x      <= '0;
              o_y      <= '0;
              o_z      <= '0;
              o_w      <= i_w;
              o_reject <= 1'b1;
            end
          end
        end
        DIV_X, DIV_Y, DIV_Z: begin
          if (lastStep) begin
            bitCount <= '0;
            remReg   <= '0;
            case (state)
              DIV_X: begin
                ndcX   <= stageResult;
                divQuo <= absShift(yReg);
              end
              DIV_Y: begin
                ndcY   <= stageResult;
                divQuo <= absShift(zReg);
              end
              default: begin
                ndcZ   <= stageResult;
                divQuo <= '0;
              end
            endcase
          end else begin
            bitCount <= bitCount + 1'b1;
            remReg   <= remNext;
            divQuo   <= divQuoNext;
          end
        end
        VIEWPORT: begin
          o_x      <= fixMul(ndcX, halfW) + halfW;
          o_y      <= fixMul(ndcY, halfH) + halfH;
          o_z      <= ndcZ;
          o_w      <= wReg;
          o_reject <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
